trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have inputs exc_illegal, exc_ecall, exc_saf, exc_laf, irq, mret  (1 each): MEM-stage trap/return requests.
REQ-003 SHALL have inputs epc_cur [31:0] (faulting PC), epc_next [31:0] (oldest unflushed PC), bad_inst [31:0], bad_addr [31:0].
REQ-004 SHALL have inputs csr_inst_req 1, csr_inst_addr [11:0], csr_inst_wdata [31:0], csr_inst_mode [1:0]: CSR-instruction write requester.
REQ-005 SHALL have output csr_inst_ack 1: CSR-instruction write granted this cycle.
REQ-006 SHALL have outputs csr_w 1, csr_waddr [11:0], csr_wdata [31:0], csr_wsc_mode [1:0], csr_raddr [11:0] to the CSR file.
REQ-007 SHALL have inputs csr_rdata [31:0] (combinational read of csr_raddr) and mstatus [31:0].
REQ-008 SHALL have outputs stall 1, flush 1, redirect 1, pc_redirect [31:0], regwrite_cancel 1.

Function
REQ-009 SHALL implement FSM states IDLE, EPC, CAUSE, TVAL, STATUS, VEC, MRET.
REQ-010 trap_valid = exc_illegal|exc_ecall|exc_saf|exc_laf|(irq & mstatus[3]); irq with MIE=0 SHALL be ignored.
REQ-011 Priority, highest first: illegal (cause 2), ecall (11), saf (7), laf (5), irq (0x8000000B).
REQ-012 In IDLE with trap_valid: latch cause; epc = epc_next for irq, else epc_cur; tval = bad_inst (illegal), bad_addr (saf/laf), else 0; assert flush; go to EPC.
REQ-013 regwrite_cancel SHALL be 1 in that detect cycle for synchronous exceptions only, 0 for irq.
REQ-014 EPC/CAUSE/TVAL/STATUS SHALL each assert csr_w=1, csr_wsc_mode=2'b01, waddr 0x341/0x342/0x343/0x300, advancing one state per cycle.
REQ-015 STATUS wdata = mstatus with MPIE(bit7)=MIE(bit3), MIE=0, MPP[12:11]=2'b11.
REQ-016 VEC SHALL set csr_raddr=0x305, redirect=1, flush=1, pc_redirect = csr_rdata & ~32'h3, csr_w=0; next IDLE.
REQ-017 In IDLE with mret and no trap_valid: go to MRET; trap_valid SHALL win over simultaneous mret.
REQ-018 MRET state SHALL, in one cycle: csr_raddr=0x341, pc_redirect=csr_rdata, redirect=1, flush=1; write 0x300 with MIE=MPIE, MPIE=1, MPP=2'b11; next IDLE.
REQ-019 stall SHALL be 1 in every non-IDLE state, 0 in IDLE.
REQ-020 In IDLE with no trap_valid and no mret, csr_inst_req SHALL pass through combinationally (csr_w, waddr, wdata, mode, raddr=csr_inst_addr) with csr_inst_ack=1.
REQ-021 csr_inst_ack SHALL be 0 when a trap or mret is accepted the same cycle, and in all non-IDLE states.
REQ-022 All request inputs SHALL be ignored outside IDLE; latched epc/cause/tval SHALL hold until the next trap.
REQ-023 Trap latency: detect cycle T, CSR writes T+1..T+4, redirect at T+5, IDLE at T+6.
REQ-024 MRET latency: accept at T, redirect and mstatus write at T+1, IDLE at T+2.
REQ-025 When not otherwise driven, csr_w, redirect, flush, regwrite_cancel, csr_inst_ack SHALL be 0 and address/data outputs 0.

Reset
REQ-026 rst SHALL force IDLE and clear latched epc/cause/tval on the clock edge, including mid-sequence.
REQ-027 While rst=1 all outputs SHALL be 0 and no CSR write SHALL occur.

Verification
REQ-028 exc_illegal, epc_cur=0x100, bad_inst=0xFFFFFFFF, mtvec=0x200 -> writes 0x341=0x100, 0x342=2, 0x343=0xFFFFFFFF, then mstatus write; redirect, pc 0x200 at T+5.
REQ-029 irq=1, exc_laf=1 together, bad_addr=0x44 -> cause 5, tval 0x44, regwrite_cancel=1 at T.
REQ-030 irq with mstatus=0x8 -> cause 0x8000000B, epc=epc_next, mstatus write 0x1880; with mstatus=0 -> no trap.
REQ-031 mret, mepc=0x104, mstatus=0x1880 -> pc_redirect 0x104 at T+1, mstatus write 0x1888, stall=1 one cycle.
REQ-032 csr_inst_req in IDLE -> ack=1 same cycle; csr_inst_req during CAUSE -> ack=0, stall=1.
REQ-033 rst asserted in TVAL -> next cycle IDLE, no STATUS write, no redirect.

Source files
------------

// File: rtl/trap_sequencer.sv
// Trap/return sequencer: serialises trap CSR updates (mepc, mcause, mtval, mstatus) and then redirects to mtvec; also handles mret.
// Latency: a trap is detected at T, writes CSRs T+1..T+4, redirects at T+5 and is idle at T+6; mret redirects at T+1.
// Backpressure: holds stall high in every non-idle state; CSR-instruction writes get a grant only in idle with no trap or mret.
module trap_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_illegal,
    input  logic        exc_ecall,
    input  logic        exc_saf,
    input  logic        exc_laf,
    input  logic        irq,
    input  logic        mret,
    input  logic [31:0] epc_cur,
    input  logic [31:0] epc_next,
    input  logic [31:0] bad_inst,
    input  logic [31:0] bad_addr,
    input  logic        csr_inst_req,
    input  logic [11:0] csr_inst_addr,
    input  logic [31:0] csr_inst_wdata,
    input  logic [1:0]  csr_inst_mode,
    output logic        csr_inst_ack,
    output logic        csr_w,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [1:0]  csr_wsc_mode,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] mstatus,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] pc_redirect,
    output logic        regwrite_cancel
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [1:0]  MODE_WRITE   = 2'b01;

    typedef enum logic [2:0] {IDLE, EPC, CAUSE, TVAL, STATUS, VEC, MRET} state_t;

    state_t      state;
    logic [31:0] epc_q;
    logic [31:0] cause_q;
    logic [31:0] tval_q;

    logic        sync_exc;
    logic        trap_valid;
    logic [31:0] cause_sel;
    logic [31:0] tval_sel;
    logic [31:0] trap_status;
    logic [31:0] mret_status;

    assign sync_exc   = exc_illegal | exc_ecall | exc_saf | exc_laf;
    assign trap_valid = sync_exc | (irq & mstatus[3]);

    always_comb begin
        cause_sel = 32'h8000_000B;
        tval_sel  = 32'h0;
        if (exc_illegal) begin
            cause_sel = 32'd2;
            tval_sel  = bad_inst;
        end else if (exc_ecall) begin
            cause_sel = 32'd11;
        end else if (exc_saf) begin
            cause_sel = 32'd7;
            tval_sel  = bad_addr;
        end else if (exc_laf) begin
            cause_sel = 32'd5;
            tval_sel  = bad_addr;
        end
    end

    // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. Return: MIE<=MPIE, MPIE<=1, MPP<=M.
    assign trap_status = {mstatus[31:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
    assign mret_status = {mstatus[31:13], 2'b11, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            epc_q   <= 32'h0;
            cause_q <= 32'h0;
            tval_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        epc_q   <= sync_exc ? epc_cur : epc_next;
                        cause_q <= cause_sel;
                        tval_q  <= tval_sel;
                        state   <= EPC;
                    end else if (mret) begin
                        state <= MRET;
                    end
                end
                EPC:     state <= CAUSE;
                CAUSE:   state <= TVAL;
                TVAL:    state <= STATUS;
                STATUS:  state <= VEC;
                VEC:     state <= IDLE;
                MRET:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_inst_ack    = 1'b0;
        csr_w           = 1'b0;
        csr_waddr       = 12'h0;
        csr_wdata       = 32'h0;
        csr_wsc_mode    = 2'b00;
        csr_raddr       = 12'h0;
        stall           = 1'b0;
        flush           = 1'b0;
        redirect        = 1'b0;
        pc_redirect     = 32'h0;
        regwrite_cancel = 1'b0;
        if (!rst) begin
            stall = (state != IDLE);
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        flush           = 1'b1;
                        regwrite_cancel = sync_exc;
                    end else if (!mret && csr_inst_req) begin
                        csr_inst_ack = 1'b1;
                        csr_w        = 1'b1;
                        csr_waddr    = csr_inst_addr;
                        csr_wdata    = csr_inst_wdata;
                        csr_wsc_mode = csr_inst_mode;
                        csr_raddr    = csr_inst_addr;
                    end
                end
                EPC: begin
                    csr_w        = 1'b1;
                    csr_wsc_mode = MODE_WRITE;
                    csr_waddr    = ADDR_MEPC;
                    csr_wdata    = epc_q;
                end
                CAUSE: begin
                    csr_w        = 1'b1;
                    csr_wsc_mode = MODE_WRITE;
                    csr_waddr    = ADDR_MCAUSE;
                    csr_wdata    = cause_q;
                end
                TVAL: begin
                    csr_w        = 1'b1;
                    csr_wsc_mode = MODE_WRITE;
                    csr_waddr    = ADDR_MTVAL;
                    csr_wdata    = tval_q;
                end
                STATUS: begin
                    csr_w        = 1'b1;
                    csr_wsc_mode = MODE_WRITE;
                    csr_waddr    = ADDR_MSTATUS;
                    csr_wdata    = trap_status;
                end
                VEC: begin
                    csr_raddr   = ADDR_MTVEC;
                    redirect    = 1'b1;
                    flush       = 1'b1;
                    pc_redirect = csr_rdata & ~32'h3;
                end
                MRET: begin
                    csr_raddr    = ADDR_MEPC;
                    redirect     = 1'b1;
                    flush        = 1'b1;
                    pc_redirect  = csr_rdata;
                    csr_w        = 1'b1;
                    csr_wsc_mode = MODE_WRITE;
                    csr_waddr    = ADDR_MSTATUS;
                    csr_wdata    = mret_status;
                end
                default: stall = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: transaction-level model (queue of pending sequence steps) checked every cycle, plus directed literal checks.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        exc_illegal, exc_ecall, exc_saf, exc_laf, irq, mret;
    logic [31:0] epc_cur, epc_next, bad_inst, bad_addr;
    logic        csr_inst_req;
    logic [11:0] csr_inst_addr;
    logic [31:0] csr_inst_wdata;
    logic [1:0]  csr_inst_mode;
    logic        csr_inst_ack, csr_w;
    logic [11:0] csr_waddr, csr_raddr;
    logic [31:0] csr_wdata, csr_rdata, mstatus, pc_redirect;
    logic [1:0]  csr_wsc_mode;
    logic        stall, flush, redirect, regwrite_cancel;

    logic [31:0] mtvec_v, mepc_v;

    int checks = 0;
    int errors = 0;

    trap_sequencer dut (
        .clk(clk), .rst(rst),
        .exc_illegal(exc_illegal), .exc_ecall(exc_ecall), .exc_saf(exc_saf), .exc_laf(exc_laf),
        .irq(irq), .mret(mret),
        .epc_cur(epc_cur), .epc_next(epc_next), .bad_inst(bad_inst), .bad_addr(bad_addr),
        .csr_inst_req(csr_inst_req), .csr_inst_addr(csr_inst_addr),
        .csr_inst_wdata(csr_inst_wdata), .csr_inst_mode(csr_inst_mode),
        .csr_inst_ack(csr_inst_ack),
        .csr_w(csr_w), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_wsc_mode(csr_wsc_mode), .csr_raddr(csr_raddr),
        .csr_rdata(csr_rdata), .mstatus(mstatus),
        .stall(stall), .flush(flush), .redirect(redirect),
        .pc_redirect(pc_redirect), .regwrite_cancel(regwrite_cancel)
    );

    // Environment CSR file: the bench owns mtvec and mepc contents.
    always_comb begin
        case (csr_raddr)
            12'h305: csr_rdata = mtvec_v;
            12'h341: csr_rdata = mepc_v;
            default: csr_rdata = {20'hDEAD0, csr_raddr};
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int ST_EPC = 1, ST_CAUSE = 2, ST_TVAL = 3, ST_STATUS = 4, ST_VEC = 5, ST_MRET = 6;
    int          pend_q[$];
    logic [31:0] m_epc, m_cause, m_tval;
    logic        m_sync, m_tv;
    logic        e_ack, e_w, e_stall, e_flush, e_redirect, e_rc;
    logic [11:0] e_waddr, e_raddr;
    logic [31:0] e_wdata, e_pc;
    logic [1:0]  e_mode;
    logic [95:0] e_vec, a_vec;

    always @(negedge clk) begin
        m_sync = exc_illegal | exc_ecall | exc_saf | exc_laf;
        m_tv   = m_sync | (irq & mstatus[3]);
        {e_ack, e_w, e_stall, e_flush, e_redirect, e_rc} = 6'b0;
        e_waddr = 12'h0; e_raddr = 12'h0; e_wdata = 32'h0; e_pc = 32'h0; e_mode = 2'b00;
        if (!rst) begin
            if (pend_q.size() > 0) begin
                e_stall = 1'b1;
                case (pend_q[0])
                    ST_EPC:    begin e_w = 1; e_mode = 2'b01; e_waddr = 12'h341; e_wdata = m_epc; end
                    ST_CAUSE:  begin e_w = 1; e_mode = 2'b01; e_waddr = 12'h342; e_wdata = m_cause; end
                    ST_TVAL:   begin e_w = 1; e_mode = 2'b01; e_waddr = 12'h343; e_wdata = m_tval; end
                    ST_STATUS: begin
                        e_w = 1; e_mode = 2'b01; e_waddr = 12'h300;
                        e_wdata = (mstatus & ~32'h1888) | 32'h1800 | (mstatus[3] ? 32'h80 : 32'h0);
                    end
                    ST_VEC:    begin e_raddr = 12'h305; e_redirect = 1; e_flush = 1; e_pc = mtvec_v & ~32'h3; end
                    default: begin
                        e_raddr = 12'h341; e_redirect = 1; e_flush = 1; e_pc = mepc_v;
                        e_w = 1; e_mode = 2'b01; e_waddr = 12'h300;
                        e_wdata = (mstatus & ~32'h1888) | 32'h1880 | (mstatus[7] ? 32'h8 : 32'h0);
                    end
                endcase
            end else if (m_tv) begin
                e_flush = 1'b1;
                e_rc    = m_sync;
            end else if (!mret && csr_inst_req) begin
                e_ack = 1; e_w = 1; e_waddr = csr_inst_addr; e_raddr = csr_inst_addr;
                e_wdata = csr_inst_wdata; e_mode = csr_inst_mode;
            end
        end
        e_vec = {e_ack, e_w, e_waddr, e_wdata, e_mode, e_raddr, e_stall, e_flush, e_redirect, e_pc, e_rc};
        a_vec = {csr_inst_ack, csr_w, csr_waddr, csr_wdata, csr_wsc_mode, csr_raddr,
                 stall, flush, redirect, pc_redirect, regwrite_cancel};
        checks++;
        if (a_vec !== e_vec) begin
            errors++;
            $display("FAIL cycle_model t=%0t: got ack/w/waddr/wdata/mode/raddr/stall/flush/redir/pc/rc=%h expected %h",
                     $time, a_vec, e_vec);
        end
        // advance the model for the coming clock edge
        if (rst) begin
            pend_q.delete();
            m_epc = 0; m_cause = 0; m_tval = 0;
        end else if (pend_q.size() > 0) begin
            void'(pend_q.pop_front());
        end else if (m_tv) begin
            m_epc = m_sync ? epc_cur : epc_next;
            if (exc_illegal)    begin m_cause = 2;  m_tval = bad_inst; end
            else if (exc_ecall) begin m_cause = 11; m_tval = 0; end
            else if (exc_saf)   begin m_cause = 7;  m_tval = bad_addr; end
            else if (exc_laf)   begin m_cause = 5;  m_tval = bad_addr; end
            else                begin m_cause = 32'h8000000B; m_tval = 0; end
            pend_q = '{ST_EPC, ST_CAUSE, ST_TVAL, ST_STATUS, ST_VEC};
        end else if (mret) begin
            pend_q.push_back(ST_MRET);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr_req();
        exc_illegal = 0; exc_ecall = 0; exc_saf = 0; exc_laf = 0; irq = 0; mret = 0;
        csr_inst_req = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            smp();
        end
    endtask

    initial begin
        rst = 1; clr_req();
        epc_cur = 0; epc_next = 0; bad_inst = 0; bad_addr = 0;
        csr_inst_addr = 12'h0; csr_inst_wdata = 0; csr_inst_mode = 0;
        mstatus = 0; mtvec_v = 32'h200; mepc_v = 0;
        // requests under reset must be ignored
        exc_illegal = 1; csr_inst_req = 1; csr_inst_addr = 12'h7C0;
        smp();
        chk("rst_ack", {31'b0, csr_inst_ack}, 0);
        chk("rst_csr_w", {31'b0, csr_w}, 0);
        chk("rst_flush", {31'b0, flush}, 0);
        cyc(); smp();

        // illegal instruction trap
        cyc(); rst = 0; clr_req();
        exc_illegal = 1; epc_cur = 32'h100; bad_inst = 32'hFFFFFFFF; mstatus = 32'h8;
        smp();
        chk("ill_flush", {31'b0, flush}, 1);
        chk("ill_cancel", {31'b0, regwrite_cancel}, 1);
        chk("ill_stall_T", {31'b0, stall}, 0);
        cyc(); clr_req(); smp();
        chk("ill_epc_addr", {20'b0, csr_waddr}, 32'h341);
        chk("ill_epc_data", csr_wdata, 32'h100);
        cyc(); smp();
        chk("ill_cause", csr_wdata, 32'd2);
        cyc(); smp();
        chk("ill_tval", csr_wdata, 32'hFFFFFFFF);
        cyc(); smp();
        chk("ill_status_addr", {20'b0, csr_waddr}, 32'h300);
        chk("ill_status_data", csr_wdata, 32'h1880);
        cyc(); smp();
        chk("ill_redirect", {31'b0, redirect}, 1);
        chk("ill_pc", pc_redirect, 32'h200);
        cyc(); smp();
        chk("ill_idle_stall", {31'b0, stall}, 0);

        // laf beats irq
        cyc(); irq = 1; exc_laf = 1; bad_addr = 32'h44; mstatus = 32'h8;
        smp();
        chk("laf_cancel", {31'b0, regwrite_cancel}, 1);
        cyc(); clr_req(); smp();
        cyc(); smp();
        chk("laf_cause", csr_wdata, 32'd5);
        cyc(); smp();
        chk("laf_tval", csr_wdata, 32'h44);
        drain(3);

        // interrupt with MIE set, then masked
        cyc(); irq = 1; mstatus = 32'h8; epc_next = 32'h300; epc_cur = 32'h111;
        smp();
        chk("irq_flush", {31'b0, flush}, 1);
        chk("irq_cancel", {31'b0, regwrite_cancel}, 0);
        cyc(); clr_req(); smp();
        chk("irq_epc", csr_wdata, 32'h300);
        cyc(); smp();
        chk("irq_cause", csr_wdata, 32'h8000000B);
        cyc(); smp();
        cyc(); smp();
        chk("irq_status", csr_wdata, 32'h1880);
        cyc(); smp();
        cyc(); irq = 1; mstatus = 32'h0;
        smp();
        chk("irq_masked_flush", {31'b0, flush}, 0);
        cyc(); clr_req(); smp();
        chk("irq_masked_stall", {31'b0, stall}, 0);

        // mret
        cyc(); mret = 1; mepc_v = 32'h104; mstatus = 32'h1880;
        smp();
        chk("mret_T_stall", {31'b0, stall}, 0);
        cyc(); clr_req(); smp();
        chk("mret_pc", pc_redirect, 32'h104);
        chk("mret_redirect", {31'b0, redirect}, 1);
        chk("mret_status", csr_wdata, 32'h1888);
        chk("mret_stall", {31'b0, stall}, 1);
        cyc(); smp();
        chk("mret_done_stall", {31'b0, stall}, 0);

        // CSR instruction grant in idle, refused mid-sequence
        cyc(); csr_inst_req = 1; csr_inst_addr = 12'h123; csr_inst_wdata = 32'h55; csr_inst_mode = 2'b10;
        smp();
        chk("csr_ack_idle", {31'b0, csr_inst_ack}, 1);
        chk("csr_waddr_idle", {20'b0, csr_waddr}, 32'h123);
        cyc(); clr_req(); exc_ecall = 1; mret = 1; smp();
        chk("ecall_over_mret", {31'b0, flush}, 1);
        cyc(); clr_req(); smp();
        chk("ecall_epc_addr", {20'b0, csr_waddr}, 32'h341);
        cyc(); csr_inst_req = 1; smp();
        chk("csr_ack_busy", {31'b0, csr_inst_ack}, 0);
        chk("csr_busy_stall", {31'b0, stall}, 1);
        chk("ecall_cause", csr_wdata, 32'd11);
        cyc(); clr_req(); smp();
        drain(2);

        // reset in the middle of a sequence
        cyc(); exc_saf = 1; bad_addr = 32'h80; smp();
        cyc(); clr_req(); smp();
        cyc(); smp();
        cyc(); rst = 1; smp();
        chk("rst_tval_w", {31'b0, csr_w}, 0);
        cyc(); rst = 0; smp();
        chk("rst_after_stall", {31'b0, stall}, 0);
        chk("rst_after_w", {31'b0, csr_w}, 0);
        cyc(); smp();
        chk("rst_after_redirect", {31'b0, redirect}, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst          = ($urandom_range(0, 63) == 0);
            exc_illegal  = ($urandom_range(0, 19) == 0);
            exc_ecall    = ($urandom_range(0, 19) == 0);
            exc_saf      = ($urandom_range(0, 19) == 0);
            exc_laf      = ($urandom_range(0, 19) == 0);
            irq          = ($urandom_range(0, 7) == 0);
            mret         = ($urandom_range(0, 9) == 0);
            csr_inst_req = $urandom_range(0, 1) == 1;
            csr_inst_addr  = 12'($urandom);
            csr_inst_wdata = $urandom;
            csr_inst_mode  = 2'($urandom);
            epc_cur  = $urandom; epc_next = $urandom;
            bad_inst = $urandom; bad_addr = $urandom;
            mstatus  = $urandom;
            if ($urandom_range(0, 15) == 0) mtvec_v = $urandom;
            if ($urandom_range(0, 15) == 0) mepc_v = $urandom;
            smp();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
